// File: rtl/flash_cmd_seq.sv
// rtl/flash_cmd_seq.sv - command sequencer for the on-chip flash data and CSR Avalon-MM ports
// Optional bounded status polling: define FLASH_SEQ_TIMEOUT_EN.
module flash_cmd_seq #(
   parameter int ADDR_WIDTH    = 16,
   parameter int DATA_WIDTH    = 32,
   parameter int BURST_WIDTH   = 2,
   parameter int LEN_WIDTH     = 8,
   parameter int TIMEOUT_POLLS = 1024
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr,
   input  logic [LEN_WIDTH-1:0]   cmd_len,
   input  logic [DATA_WIDTH-1:0]  cmd_wdata,
   output logic                   rd_valid,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   done,
   output logic                   err,
   output logic                   avmm_csr_addr,
   output logic                   avmm_csr_read,
   output logic                   avmm_csr_write,
   output logic [DATA_WIDTH-1:0]  avmm_csr_writedata,
   input  logic [DATA_WIDTH-1:0]  avmm_csr_readdata,
   output logic [ADDR_WIDTH-1:0]  avmm_data_addr,
   output logic                   avmm_data_read,
   output logic                   avmm_data_write,
   output logic [DATA_WIDTH-1:0]  avmm_data_writedata,
   input  logic [DATA_WIDTH-1:0]  avmm_data_readdata,
   input  logic                   avmm_data_waitrequest,
   input  logic                   avmm_data_readdatavalid,
   output logic [BURST_WIDTH-1:0] avmm_data_burstcount
);
   localparam int          MAX_BURST   = 1 << (BURST_WIDTH - 1);
   localparam logic [1:0]  OP_READ     = 2'b00;
   localparam logic [1:0]  OP_WRITE    = 2'b01;
   localparam logic [1:0]  OP_ERASE_SEC = 2'b10;
   localparam logic [19:0] PAGE_NONE   = 20'hFFFFF;
   localparam logic [2:0]  SECTOR_NONE = 3'b111;

   typedef enum logic [3:0] {
      S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_UNPROT, S_WR,
      S_ERASE, S_POLL, S_CHK, S_REPROT, S_DONE
   } state_t;

   state_t                 r_state, w_next;
   logic [1:0]             r_op;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [LEN_WIDTH-1:0]   r_remaining;
   logic [DATA_WIDTH-1:0]  r_wdata;
   logic [BURST_WIDTH-1:0] r_beats;
   logic                   r_fail;
   logic [BURST_WIDTH-1:0] w_burst;
   logic [31:0]            w_ctrl;
   logic                   w_busy, w_success, w_timeout, w_unused;

   function automatic logic [31:0] ctrl_word(input logic [4:0] mask, input logic [2:0] sector,
                                             input logic [19:0] page);
      return {4'b0000, mask, sector, page};
   endfunction

   assign w_burst   = (r_remaining >= LEN_WIDTH'(MAX_BURST)) ? BURST_WIDTH'(MAX_BURST)
                                                             : BURST_WIDTH'(r_remaining);
   assign w_busy    = (avmm_csr_readdata[1:0] != 2'b00);
   assign w_success = (r_op == OP_WRITE) ? avmm_csr_readdata[3] : avmm_csr_readdata[4];
   assign rd_valid  = (r_state == S_RD_WAIT) && avmm_data_readdatavalid;
   assign rd_data   = rd_valid ? avmm_data_readdata : '0;

`ifdef FLASH_SEQ_TIMEOUT_EN
   localparam int POLL_W = $clog2(TIMEOUT_POLLS + 1);
   logic [POLL_W-1:0] r_polls;

   always_ff @(posedge clock) begin
      if (reset || r_state == S_IDLE) r_polls <= '0;
      else if (r_state == S_POLL)     r_polls <= r_polls + POLL_W'(1);
   end

   assign w_timeout = (r_polls >= POLL_W'(TIMEOUT_POLLS));
   assign w_unused  = ^{avmm_csr_readdata[DATA_WIDTH-1:5], avmm_csr_readdata[2]};
`else
   assign w_timeout = 1'b0;
   assign w_unused  = ^{avmm_csr_readdata[DATA_WIDTH-1:5], avmm_csr_readdata[2], TIMEOUT_POLLS != 0};
`endif

   // Write-protect is only lifted around write/erase; erase selects exactly one of sector or page.
   always_comb begin
      w_ctrl = ctrl_word(5'h00, SECTOR_NONE, PAGE_NONE);
      if (r_state == S_REPROT)
         w_ctrl = ctrl_word(5'h1F, SECTOR_NONE, PAGE_NONE);
      else if (r_state == S_ERASE && r_op == OP_ERASE_SEC)
         w_ctrl = ctrl_word(5'h00, r_addr[2:0], PAGE_NONE);
      else if (r_state == S_ERASE)
         w_ctrl = ctrl_word(5'h00, SECTOR_NONE, 20'(r_addr));
   end

   always_comb begin
      w_next               = r_state;
      cmd_ready            = 1'b0;
      done                 = 1'b0;
      err                  = 1'b0;
      avmm_csr_addr        = 1'b0;
      avmm_csr_read        = 1'b0;
      avmm_csr_write       = 1'b0;
      avmm_csr_writedata   = '0;
      avmm_data_addr       = '0;
      avmm_data_read       = 1'b0;
      avmm_data_write      = 1'b0;
      avmm_data_writedata  = '0;
      avmm_data_burstcount = BURST_WIDTH'(1);
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_op != OP_READ)  w_next = S_UNPROT;
               else if (cmd_len == '0) w_next = S_DONE;
               else                    w_next = S_RD_ISSUE;
            end
         end
         S_RD_ISSUE: begin
            avmm_data_read       = 1'b1;
            avmm_data_addr       = r_addr;
            avmm_data_burstcount = w_burst;
            if (!avmm_data_waitrequest) w_next = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (avmm_data_readdatavalid && r_beats == BURST_WIDTH'(1))
               w_next = (r_remaining != '0) ? S_RD_ISSUE : S_DONE;
         end
         S_UNPROT, S_ERASE, S_REPROT: begin
            avmm_csr_write     = 1'b1;
            avmm_csr_addr      = 1'b1;
            avmm_csr_writedata = DATA_WIDTH'(w_ctrl);
            if (r_state == S_UNPROT)     w_next = (r_op == OP_WRITE) ? S_WR : S_ERASE;
            else if (r_state == S_ERASE) w_next = S_POLL;
            else                         w_next = S_DONE;
         end
         S_WR: begin
            avmm_data_write     = 1'b1;
            avmm_data_addr      = r_addr;
            avmm_data_writedata = r_wdata;
            if (!avmm_data_waitrequest) w_next = S_POLL;
         end
         S_POLL: begin
            avmm_csr_read = 1'b1;
            w_next        = S_CHK;
         end
         S_CHK: begin
            if (w_busy && !w_timeout) w_next = S_POLL;
            else                      w_next = S_REPROT;
         end
         S_DONE: begin
            done   = 1'b1;
            err    = r_fail;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_op        <= '0;
         r_addr      <= '0;
         r_remaining <= '0;
         r_wdata     <= '0;
         r_beats     <= '0;
         r_fail      <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (cmd_valid) begin
               r_op        <= cmd_op;
               r_addr      <= cmd_addr;
               r_remaining <= cmd_len;
               r_wdata     <= cmd_wdata;
               r_fail      <= 1'b0;
            end
            // Address and remaining count advance once the burst is accepted.
            S_RD_ISSUE: if (!avmm_data_waitrequest) begin
               r_beats     <= w_burst;
               r_remaining <= r_remaining - LEN_WIDTH'(w_burst);
               r_addr      <= r_addr + ADDR_WIDTH'(w_burst);
            end
            S_RD_WAIT: if (avmm_data_readdatavalid) r_beats <= r_beats - BURST_WIDTH'(1);
            S_CHK: begin
               if (!w_busy)        r_fail <= !w_success;
               else if (w_timeout) r_fail <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
